sr_fetch: RTL

Instruction fetch stage of the schoolRISCV core, directly upstream of the decoder/control logic. Owns the fetch PC, issues requests to the instruction memory over a grant/valid handshake with variable, in-order latency, and buffers returned words in a small FIFO. Presents one instruction plus its PC to decode with a valid/ready handshake. A redirect from the branch logic (pcSrc path) flushes buffered and in-flight fetches.

---
 rtl/sr_fetch.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/sr_fetch.sv
// sr_fetch - instruction fetch stage of the schoolRISCV core.
//
// Owns the fetch PC and issues word requests to instruction memory over a
// grant/valid handshake. Memory latency is variable but in-order. Returned
// words go into a DEPTH-entry buffer of {word, pc} entries, and decode reads
// them through a valid/ready handshake. A redirect from the branch logic
// flushes the buffer. Requests still in flight at a redirect are counted into
// a discard counter so that their responses are dropped when they return.
//
// Optional feature: define SR_FETCH_BYPASS_EN to forward a response straight
// to decode in the cycle it arrives when the buffer is empty.
//
// Parameters
//   RESET_PC    first fetch address after reset (word aligned)
//   DEPTH       buffer entries and maximum outstanding requests (power of 2, >= 2)
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   imReq, imAddr         fetch request and word address
//   imGnt                 memory accepts the request (imReq & imGnt = issue)
//   imRvalid, imRdata     in-order response word
//   redirect, redirectPc  branch taken: flush and restart at redirectPc
//   instrValid, instrReady, instr, instrPc   decode handshake and payload
module sr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imReq,
   output logic [31:0] imAddr,
   input  logic        imGnt,
   input  logic        imRvalid,
   input  logic [31:0] imRdata,
   input  logic        redirect,
   input  logic [31:0] redirectPc,
   output logic        instrValid,
   input  logic        instrReady,
   output logic [31:0] instr,
   output logic [31:0] instrPc
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);
   localparam logic [CntW:0] DepthC = (CntW + 1)'(DEPTH);

   typedef enum logic [0:0] {StBoot, StRun} stateT;

   stateT           stateQ, stateD;
   logic [31:0]     fetchPcQ, fetchPcD;
   logic [CntW-1:0] inflightQ, inflightD;
   logic [CntW-1:0] discardQ, discardD;
   logic [CntW-1:0] bufCntQ, bufCntD;
   logic [PtrW-1:0] bufRdQ, bufRdD, bufWrQ, bufWrD;
   logic [PtrW-1:0] tagRdQ, tagWrQ;

   logic [31:0] tagMem  [DEPTH];
   logic [31:0] bufWord [DEPTH];
   logic [31:0] bufPc   [DEPTH];

   logic issue, bufEmpty, respKeep, bypassHit, pop, popBuf, pushBuf;

   assign issue    = imReq & imGnt;
   assign bufEmpty = (bufCntQ == '0);
   // A response is kept only if it is not stale and not racing a redirect.
   assign respKeep = imRvalid & (discardQ == '0) & ~redirect;

`ifdef SR_FETCH_BYPASS_EN
   assign bypassHit = respKeep & bufEmpty;
`else
   assign bypassHit = 1'b0;
`endif

   assign pop     = instrValid & instrReady;
   assign popBuf  = pop & ~bufEmpty;
   // A bypassed word that decode takes immediately never enters the buffer.
   assign pushBuf = respKeep & ~(bypassHit & instrReady);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ <= StBoot;
      end else begin
         stateQ <= stateD;
      end
   end

   always_comb begin
      stateD = stateQ;
      unique case (stateQ)
         StBoot: stateD = StRun;
         StRun:  stateD = StRun;
      endcase
   end

   // Stale requests still hold credits until they return.
   always_comb begin
      imReq  = (stateQ == StRun) && (({1'b0, inflightQ} + {1'b0, bufCntQ}) < DepthC);
      imAddr = fetchPcQ;
   end

   // ------------------------------------------------------ decode output
   always_comb begin
      instrValid = ~bufEmpty;
      instr      = '0;
      instrPc    = '0;
      if (!bufEmpty) begin
         instr   = bufWord[bufRdQ];
         instrPc = bufPc[bufRdQ];
      end
`ifdef SR_FETCH_BYPASS_EN
      else if (bypassHit) begin
         instrValid = 1'b1;
         instr      = imRdata;
         instrPc    = tagMem[tagRdQ];
      end
`endif
   end

   // ------------------------------------------------------ next state
   always_comb begin
      fetchPcD = fetchPcQ;
      if (redirect) begin
         fetchPcD = {redirectPc[31:2], 2'b00};
      end else if (issue) begin
         fetchPcD = fetchPcQ + 32'd4;
      end

      inflightD = inflightQ + CntW'(issue) - CntW'(imRvalid);

      // Everything still outstanding after a redirect cycle is stale.
      discardD = discardQ;
      if (redirect) begin
         discardD = inflightD;
      end else if (imRvalid && (discardQ != '0)) begin
         discardD = discardQ - 1'b1;
      end

      bufRdD  = bufRdQ;
      bufWrD  = bufWrQ;
      bufCntD = bufCntQ;
      if (redirect) begin
         bufRdD  = bufWrQ;
         bufCntD = '0;
      end else begin
         if (pushBuf) bufWrD = bufWrQ + 1'b1;
         if (popBuf)  bufRdD = bufRdQ + 1'b1;
         bufCntD = bufCntQ + CntW'(pushBuf) - CntW'(popBuf);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetchPcQ  <= RESET_PC;
         inflightQ <= '0;
         discardQ  <= '0;
         bufCntQ   <= '0;
         bufRdQ    <= '0;
         bufWrQ    <= '0;
         tagRdQ    <= '0;
         tagWrQ    <= '0;
      end else begin
         fetchPcQ  <= fetchPcD;
         inflightQ <= inflightD;
         discardQ  <= discardD;
         bufCntQ   <= bufCntD;
         bufRdQ    <= bufRdD;
         bufWrQ    <= bufWrD;
         if (issue)    tagWrQ <= tagWrQ + 1'b1;
         if (imRvalid) tagRdQ <= tagRdQ + 1'b1;
      end
   end

   // Storage arrays carry no reset; occupancy is tracked by the counters.
   always_ff @(posedge clk) begin
      if (issue) begin
         tagMem[tagWrQ] <= fetchPcQ;
      end
      if (pushBuf) begin
         bufWord[bufWrQ] <= imRdata;
         bufPc[bufWrQ]   <= tagMem[tagRdQ];
      end
   end

endmodule
